// File: rtl/snn_interfaces_pkg.sv
// Shared SNN interface types: coordinate vector, packing helper, default
// image geometry and the event_ingress FSM state encoding.
package snn_interfaces_pkg;

  localparam int DEFAULT_COORD_BITS = 8;
  localparam int DEFAULT_IMG_WIDTH  = 64;
  localparam int DEFAULT_IMG_HEIGHT = 48;

  typedef struct packed {
    logic [DEFAULT_COORD_BITS-1:0] x;
    logic [DEFAULT_COORD_BITS-1:0] y;
  } vec2_t;

  // x in the upper half, y in the lower half
  function automatic logic [2*DEFAULT_COORD_BITS-1:0] pack_coordinates(vec2_t v);
    return {v.x, v.y};
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    WAIT = 2'd2
  } ingress_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the ingress statistics.
// Ports: clk, rst_n (async clear, active low), inc_en (add INC this edge),
//        count (current value, sticks at all-ones).
module sat_counter #(
  parameter int WIDTH = 16,
  parameter int INC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum     = {1'b0, count_q} + (WIDTH+1)'(INC);
    count_d = count_q;
    if (inc_en) count_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/event_ingress.sv
// Sensor event ingress: accepts one (x,y) event at a time, drops
// out-of-range coordinates, writes in-range ones to a FIFO, waits up to
// STALL_LIMIT cycles on a full FIFO before dropping, and keeps saturating
// statistics.
// Optional feature macro: EVENT_INGRESS_DEDUP_EN -- suppress a repeat of the
// last written coordinate within DEDUP_WINDOW cycles of that write.
// Ports: clk/rst_n; enable, in_valid/in_x/in_y/in_ready (event in);
//        fifo_full, fifo_write_en/fifo_write_data (FIFO producer side);
//        oob_count, drop_count, dedup_count, busy (status).
module event_ingress
  import snn_interfaces_pkg::*;
#(
  parameter int COORD_BITS   = DEFAULT_COORD_BITS,
  parameter int IMG_WIDTH    = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT   = DEFAULT_IMG_HEIGHT,
  parameter int STALL_LIMIT  = 8,
  parameter int DEDUP_WINDOW = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [COORD_BITS-1:0]   in_x,
  input  logic [COORD_BITS-1:0]   in_y,
  output logic                    in_ready,
  input  logic                    fifo_full,
  output logic                    fifo_write_en,
  output logic [2*COORD_BITS-1:0] fifo_write_data,
  output logic [15:0]             oob_count,
  output logic [15:0]             drop_count,
  output logic [15:0]             dedup_count,
  output logic                    busy
);

  localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [SW-1:0]         STALL_LAST = SW'(STALL_LIMIT - 1);
  localparam logic [COORD_BITS:0]   X_LIM      = (COORD_BITS+1)'(IMG_WIDTH);
  localparam logic [COORD_BITS:0]   Y_LIM      = (COORD_BITS+1)'(IMG_HEIGHT);

  if (STALL_LIMIT < 1 || DEDUP_WINDOW < 1) begin : g_bad_params
    $error("event_ingress: STALL_LIMIT and DEDUP_WINDOW must be >= 1");
  end

  ingress_state_t            state_q, state_d;
  logic [COORD_BITS-1:0]     x_q, x_d, y_q, y_d;
  logic [SW-1:0]             stall_q, stall_d;
  logic                      wr_en_q, wr_en_d;
  logic [2*COORD_BITS-1:0]   wr_data_q, wr_data_d;
  logic                      run_q;
  logic                      oob, oob_inc, drop_inc;
  logic [2*COORD_BITS-1:0]   pkt;

  if (COORD_BITS == DEFAULT_COORD_BITS) begin : g_pkg_pack
    vec2_t coord;
    assign coord.x = x_q;
    assign coord.y = y_q;
    assign pkt     = pack_coordinates(coord);
  end else begin : g_local_pack
    // same field order as pack_coordinates
    assign pkt = {x_q, y_q};
  end

  assign oob = ({1'b0, x_q} >= X_LIM) || ({1'b0, y_q} >= Y_LIM);

`ifdef EVENT_INGRESS_DEDUP_EN
  localparam int WW = $clog2(DEDUP_WINDOW + 1);
  localparam logic [WW-1:0] WIN_MAX = WW'(DEDUP_WINDOW);
  logic          hist_vld_q, hist_vld_d;
  logic [WW-1:0] win_q, win_d;
  logic          is_dup, dup_inc;
  // wr_data_q already holds the last written coordinate
  assign is_dup = hist_vld_q && (pkt == wr_data_q) && (win_q < WIN_MAX);
`endif

  // run_q holds in_ready low until the first edge after reset release
  assign in_ready = run_q && (state_q == IDLE) && enable;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    stall_d   = stall_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    oob_inc   = 1'b0;
    drop_inc  = 1'b0;
`ifdef EVENT_INGRESS_DEDUP_EN
    dup_inc   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_d     = in_x;
          y_d     = in_y;
          state_d = EVAL;
        end
      end
      EVAL: begin
        state_d = IDLE;
        if (oob) oob_inc = 1'b1;
`ifdef EVENT_INGRESS_DEDUP_EN
        else if (is_dup) dup_inc = 1'b1;
`endif
        else if (!fifo_full) begin
          wr_en_d   = 1'b1;
          wr_data_d = pkt;
        end else begin
          state_d = WAIT;
          stall_d = '0;
        end
      end
      WAIT: begin
        if (!fifo_full) begin
          wr_en_d   = 1'b1;
          wr_data_d = pkt;
          state_d   = IDLE;
        end else if (stall_q == STALL_LAST) begin
          drop_inc = 1'b1;
          state_d  = IDLE;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      stall_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      stall_q   <= stall_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      run_q     <= 1'b1;
    end
  end

  assign fifo_write_en   = wr_en_q;
  assign fifo_write_data = wr_data_q;

  sat_counter #(.WIDTH(16), .INC(1)) u_oob_cnt (
    .clk(clk), .rst_n(rst_n), .inc_en(oob_inc), .count(oob_count));
  sat_counter #(.WIDTH(16), .INC(1)) u_drop_cnt (
    .clk(clk), .rst_n(rst_n), .inc_en(drop_inc), .count(drop_count));

`ifdef EVENT_INGRESS_DEDUP_EN
  // window restarts on every write and sticks at DEDUP_WINDOW
  always_comb begin
    hist_vld_d = hist_vld_q | wr_en_d;
    win_d      = win_q;
    if (wr_en_d)                win_d = '0;
    else if (win_q != WIN_MAX)  win_d = win_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_vld_q <= 1'b0;
      win_q      <= '0;
    end else begin
      hist_vld_q <= hist_vld_d;
      win_q      <= win_d;
    end
  end

  sat_counter #(.WIDTH(16), .INC(1)) u_dedup_cnt (
    .clk(clk), .rst_n(rst_n), .inc_en(dup_inc), .count(dedup_count));
`else
  assign dedup_count = '0;
`endif

endmodule

// File: doc/event_ingress.md
EVENT_INGRESS -- requirements
Module: event_ingress

Interface
REQ-001 SHALL have parameter COORD_BITS, default DEFAULT_COORD_BITS, width of each coordinate.
REQ-002 SHALL have parameter IMG_WIDTH, default DEFAULT_IMG_WIDTH, valid x range 0..IMG_WIDTH-1.
REQ-003 SHALL have parameter IMG_HEIGHT, default DEFAULT_IMG_HEIGHT, valid y range 0..IMG_HEIGHT-1.
REQ-004 SHALL have parameter STALL_LIMIT, default 8, max cycles to wait on full FIFO before dropping.
REQ-005 SHALL have parameter DEDUP_WINDOW, default 16, cycles a repeated coordinate is suppressed (REQ-030).
REQ-006 Clock and reset SHALL be one clock and an asynchronous active-low reset: clk input 1 system clock; rst_n input 1 asynchronous active-low reset.
REQ-007 Ports: enable input 1 accept new events when high.
REQ-008 Ports: in_valid input 1 sensor event present; in_x input COORD_BITS; in_y input COORD_BITS.
REQ-009 Ports: in_ready output 1 event accepted on clk edge when in_valid && in_ready.
REQ-010 Ports: fifo_full input 1 from FIFO producer side.
REQ-011 Ports: fifo_write_en output 1, fifo_write_data output 2*COORD_BITS, to FIFO producer side.
REQ-012 Ports: oob_count, drop_count, dedup_count outputs 16 each, saturating statistics; busy output 1 FSM not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, EVAL, WAIT.
REQ-014 IDLE: in_ready = enable; on in_valid && in_ready SHALL register (in_x, in_y) and go to EVAL.
REQ-015 in_ready SHALL be 0 in EVAL and WAIT (single event in flight, no skid).
REQ-016 EVAL, coordinate out of range (x >= IMG_WIDTH or y >= IMG_HEIGHT): SHALL increment oob_count, no write, return to IDLE.
REQ-017 EVAL, in range, fifo_full == 0: SHALL pulse fifo_write_en one cycle with fifo_write_data = pack_coordinates of the registered vec2_t, return to IDLE.
REQ-018 EVAL, in range, fifo_full == 1: SHALL go to WAIT and clear stall counter.
REQ-019 WAIT: each cycle with fifo_full == 0 SHALL write as REQ-017 and return to IDLE; else stall counter increments.
REQ-020 WAIT: when stall counter reaches STALL_LIMIT with fifo_full still 1, SHALL discard event, increment drop_count, return to IDLE.
REQ-021 Latency: event accepted at edge N SHALL produce fifo_write_en high in cycle following edge N+1 when FIFO not full (one cycle EVAL).
REQ-022 fifo_write_en and fifo_write_data SHALL be registered outputs; fifo_write_data holds last written value when idle.
REQ-023 Statistic counters SHALL saturate at 16'hFFFF, never wrap.
REQ-024 enable deasserted in EVAL/WAIT SHALL NOT abort the in-flight event; only blocks new acceptance.
REQ-025 Back-to-back accepted events SHALL be at most one per 2 cycles when FIFO not full.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, in_ready 0, fifo_write_en 0, fifo_write_data 0, all counters 0, busy 0, dedup history invalid.
REQ-028 Reset mid-WAIT or mid-EVAL SHALL discard the in-flight event without counting it.
REQ-029 After rst_n release, in_ready SHALL follow enable from the first clk edge.

Configuration
REQ-030 With EVENT_INGRESS_DEDUP_EN defined: in EVAL, in-range event equal to last written coordinate and fewer than DEDUP_WINDOW cycles since that write SHALL be discarded, dedup_count incremented, return to IDLE; window counter saturates.
REQ-031 Without EVENT_INGRESS_DEDUP_EN: no history/window logic synthesized; dedup_count SHALL be constant 0; all in-range events proceed per REQ-017/018.

Structure
REQ-032 vec2_t, pack_coordinates, DEFAULT_COORD_BITS/IMG_WIDTH/IMG_HEIGHT SHALL come from snn_interfaces_pkg; new ingress_state_t enum SHALL be added there.
REQ-033 A sub-module sat_counter (parameterised width, increment, async clear) SHALL implement the three statistics counters.

Verification
REQ-034 Reset, enable=1, event (5,10), fifo_full=0 -> fifo_write_en one pulse 2 cycles after accept, data = pack_coordinates(5,10), counters 0.
REQ-035 Event (IMG_WIDTH,3) -> no write, oob_count=1, in_ready high again after 2 cycles.
REQ-036 fifo_full=1 held 20 cycles, event (15,20) -> no write, drop_count=1 after STALL_LIMIT (8) WAIT cycles; fifo_full released at WAIT cycle 3 instead -> single write of (15,20), drop_count 0.
REQ-037 DEDUP_EN defined: (7,7) then (7,7) 4 cycles later -> one write, dedup_count=1; repeat after 20 cycles -> second write. Macro undefined: both writes, dedup_count=0.
REQ-038 rst_n pulsed low while in WAIT -> outputs zero immediately (asynchronous), no write after release, drop_count=0.
REQ-039 Force drop_count to 16'hFFFF then cause a drop -> remains 16'hFFFF.
